// File: rtl/axi_pkg.sv
// Shared AXI bus widths, burst/response encodings and the slave FSM states.
// Imported by every file of the SRAM slave.
package axi_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WBEAT,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } state_t;

  // WRAP and the reserved encoding are both answered with SLVERR, as is any beat wider than the bus.
  function automatic logic burst_err(input logic [1:0] burst, input logic [AXI_SIZE_BITS-1:0] size);
    return burst[1] || (size > 3'd2);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for a burst; FIXED holds the address, every other
// encoding (including WRAP) steps by the beat size like INCR.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [AXI_ADDR_BITS-1:0] i_addr,
  input  logic [AXI_SIZE_BITS-1:0] i_size,
  input  logic [1:0]               i_burst,
  output logic [AXI_ADDR_BITS-1:0] o_next_addr
);

  logic [AXI_ADDR_BITS-1:0] w_step;

  assign w_step      = {{(AXI_ADDR_BITS-1){1'b0}}, 1'b1} << i_size;
  assign o_next_addr = (i_burst == BURST_FIXED) ? i_addr : i_addr + w_step;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave that serialises one burst at a time onto a single-port SRAM,
// alternating priority between the write and read address channels.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [AXI_IDS_BITS-1:0]  AWID,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [AXI_DATA_BITS-1:0] WDATA,
  input  logic [AXI_STRB_BITS-1:0] WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [AXI_IDS_BITS-1:0]  ARID,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_IDS_BITS-1:0]  RID,
  output logic [AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic                     sram_cs,
  output logic                     sram_we,
  output logic [SRAM_AW-1:0]       sram_addr,
  output logic [31:0]              sram_wdata,
  output logic [3:0]               sram_bwe,
  input  logic [31:0]              sram_rdata
);

  state_t                   r_state;
  logic                     r_prio_w;
  logic [AXI_IDS_BITS-1:0]  r_id;
  logic [AXI_ADDR_BITS-1:0] r_addr;
  logic [AXI_LEN_BITS-1:0]  r_len;
  logic [AXI_SIZE_BITS-1:0] r_size;
  logic [1:0]               r_burst;
  logic [AXI_LEN_BITS-1:0]  r_beat_cnt;
  logic                     r_err;

  logic                     w_idle;
  logic                     w_aw_hs;
  logic                     w_ar_hs;
  logic                     w_w_hs;
  logic                     w_last_beat;
  logic [AXI_ADDR_BITS-1:0] w_next_addr;
  logic [1:0]               w_resp;

  axi_burst_addr u_burst_addr (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Ready is gated by reset so nothing can be granted while ARESET is high.
  assign w_idle      = (r_state == ST_IDLE) && !ARESET;
  assign AWREADY     = w_idle && (!ARVALID || r_prio_w);
  assign ARREADY     = w_idle && (!AWVALID || !r_prio_w);
  assign w_aw_hs     = AWVALID && AWREADY;
  assign w_ar_hs     = ARVALID && ARREADY;
  assign WREADY      = (r_state == ST_WBEAT);
  assign w_w_hs      = WVALID && WREADY;
  assign w_last_beat = (r_beat_cnt == r_len);
  assign w_resp      = r_err ? RESP_SLVERR : RESP_OKAY;

  assign BVALID = (r_state == ST_WRESP);
  assign BID    = BVALID ? r_id : '0;
  assign BRESP  = BVALID ? w_resp : RESP_OKAY;

  assign RVALID = (r_state == ST_RDATA);
  assign RID    = RVALID ? r_id : '0;
  assign RDATA  = RVALID ? sram_rdata : '0;
  assign RRESP  = RVALID ? w_resp : RESP_OKAY;
  assign RLAST  = RVALID && w_last_beat;

  assign sram_cs    = w_w_hs || (r_state == ST_RADDR);
  assign sram_we    = w_w_hs;
  assign sram_addr  = sram_cs ? r_addr[SRAM_AW+1:2] : '0;
  assign sram_wdata = w_w_hs ? WDATA : '0;
  assign sram_bwe   = w_w_hs ? WSTRB : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= ST_IDLE;
      r_prio_w   <= 1'b1;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id       <= AWID;
            r_addr     <= AWADDR;
            r_len      <= AWLEN;
            r_size     <= AWSIZE;
            r_burst    <= AWBURST;
            r_beat_cnt <= '0;
            r_err      <= burst_err(AWBURST, AWSIZE);
            r_prio_w   <= !r_prio_w;
            r_state    <= ST_WBEAT;
          end else if (w_ar_hs) begin
            r_id       <= ARID;
            r_addr     <= ARADDR;
            r_len      <= ARLEN;
            r_size     <= ARSIZE;
            r_burst    <= ARBURST;
            r_beat_cnt <= '0;
            r_err      <= burst_err(ARBURST, ARSIZE);
            r_prio_w   <= !r_prio_w;
            r_state    <= ST_RADDR;
          end
        end
        // A WLAST that does not line up with AWLEN (early or late) poisons the response.
        ST_WBEAT: begin
          if (w_w_hs) begin
            r_addr     <= w_next_addr;
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_err      <= r_err || (WLAST != w_last_beat);
            if (WLAST) begin
              r_state <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (BREADY) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          r_state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (RREADY) begin
            if (w_last_beat) begin
              r_state <= ST_IDLE;
            end else begin
              r_addr     <= w_next_addr;
              r_beat_cnt <= r_beat_cnt + 1'b1;
              r_state    <= ST_RADDR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM and hand-computed
// expected values for each burst.
module tb_axi_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        sram_cs;
  logic        sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_bwe;
  logic [31:0] sram_rdata;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] sramMem [0:16383];

  axi_sram_slave #(.SRAM_AW(14)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_bwe(sram_bwe), .sram_rdata(sram_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural single-port SRAM: byte-enabled writes, read data one cycle later and held otherwise.
  always @(posedge ACLK) begin
    if (sram_cs && sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_bwe[b]) sramMem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end else if (sram_cs) begin
      sram_rdata <= sramMem[sram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [7:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int waitCnt;
    @(negedge ACLK);
    if (isWrite) begin
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    end else begin
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    end
    waitCnt = 0;
    #1;
    while (!(isWrite ? AWREADY : ARREADY) && waitCnt < 20) begin
      @(negedge ACLK);
      #1;
      waitCnt++;
    end
    checkOutput("addrGrant", 32'(waitCnt < 20), 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    ARVALID = 1'b0;
  endtask

  task automatic writeBurst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int nBeats, input logic [31:0] base,
                            input logic [3:0] strb, input logic [1:0] expResp);
    applyStimulus(1'b1, id, addr, len, 3'd2, burst);
    for (int i = 0; i < nBeats; i++) begin
      WVALID = 1'b1; WDATA = base + i; WSTRB = strb; WLAST = (i == nBeats - 1);
      #1;
      checkOutput("wReady", WREADY, 1'b1);
      checkOutput("wCs", {sram_cs, sram_we}, 2'b11);
      checkOutput("wAddr", sram_addr, 14'((addr >> 2) + i));
      checkOutput("wData", sram_wdata, base + i);
      checkOutput("wBwe", sram_bwe, strb);
      @(posedge ACLK);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    checkOutput("bValid", BVALID, 1'b1);
    checkOutput("bResp", BRESP, expResp);
    checkOutput("bId", BID, id);
    BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    checkOutput("bDone", BVALID, 1'b0);
  endtask

  task automatic readBurst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [31:0] base, input int step,
                           input logic [1:0] expResp, input int stallBeat, input int stallCycles);
    applyStimulus(1'b0, id, addr, len, size, 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      #1;
      checkOutput("rCs", {sram_cs, sram_we, RVALID}, 3'b100);
      @(negedge ACLK);
      #1;
      checkOutput("rValid", RVALID, 1'b1);
      checkOutput("rData", RDATA, base + i * step);
      checkOutput("rLast", RLAST, i == int'(len));
      checkOutput("rResp", RRESP, expResp);
      checkOutput("rId", RID, id);
      if (i == stallBeat) begin
        RREADY = 1'b0;
        for (int s = 0; s < stallCycles; s++) begin
          @(negedge ACLK);
          #1;
          checkOutput("rHold", {RVALID, RDATA}, {1'b1, base + i * step});
        end
      end
      RREADY = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      RREADY = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) sramMem[i] = '0;
    sram_rdata = '0;
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("rstOut", {AWREADY, ARREADY, WREADY, BVALID, RVALID, sram_cs, sram_we}, 7'b0);
    ARESET = 1'b0;

    // Collision straight after reset: write wins first.
    @(negedge ACLK);
    AWVALID = 1'b1; ARVALID = 1'b1;
    #1;
    checkOutput("collide1", {AWREADY, ARREADY}, 2'b10);
    AWVALID = 1'b0; ARVALID = 1'b0;

    writeBurst(8'h3C, 32'h10, 4'd3, 2'b01, 4, 32'hA0, 4'hF, 2'b00);

    // Second collision: read has priority now.
    @(negedge ACLK);
    AWVALID = 1'b1; ARVALID = 1'b1;
    #1;
    checkOutput("collide2", {AWREADY, ARREADY}, 2'b01);
    AWVALID = 1'b0; ARVALID = 1'b0;

    readBurst(8'h5A, 32'h10, 4'd3, 3'd2, 32'hA0, 1, 2'b00, 1, 5);

    writeBurst(8'h01, 32'h100, 4'd0, 2'b01, 1, 32'hFFFFFFFF, 4'hF, 2'b00);
    writeBurst(8'h02, 32'h100, 4'd0, 2'b01, 1, 32'h11223344, 4'h5, 2'b00);
    readBurst(8'h03, 32'h100, 4'd0, 3'd2, 32'hFF22FF44, 0, 2'b00, -1, 0);

    writeBurst(8'h04, 32'h200, 4'd1, 2'b10, 2, 32'hB0, 4'hF, 2'b10);
    readBurst(8'h05, 32'h200, 4'd1, 3'd2, 32'hB0, 1, 2'b00, -1, 0);

    writeBurst(8'h06, 32'h300, 4'd3, 2'b01, 2, 32'hC0, 4'hF, 2'b10);

    readBurst(8'h07, 32'h10, 4'd1, 3'd3, 32'hA0, 2, 2'b10, -1, 0);

    // Reset in the middle of an 8-beat read.
    applyStimulus(1'b0, 8'h08, 32'h10, 4'd7, 3'd2, 2'b01);
    @(negedge ACLK);
    RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    @(negedge ACLK);
    #1;
    checkOutput("midBeat", {RVALID, RDATA}, {1'b1, 32'hA1});
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    #1;
    checkOutput("abortCtl", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, sram_cs, sram_we}, 8'b0);
    checkOutput("abortData", RDATA | {RID, RRESP, sram_addr} | sram_wdata | {BID, BRESP, sram_bwe}, 32'b0);
    ARESET = 1'b0;
    #1;
    checkOutput("postRst", {AWREADY, ARREADY}, 2'b11);
    readBurst(8'h09, 32'h14, 4'd0, 3'd2, 32'hA1, 0, 2'b00, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
